id_ex_stage: RTL
================

# id_ex_stage

Decode-to-execute pipeline register for the 5-stage RV32I core. It accepts one decoded instruction per cycle from decode and holds it in a single-entry register with a valid/ready handshake. It resolves the ALU operands through forwarding from the MEM and WB stages and inserts load-use bubbles. It drives the ALU inputs (`alu_in1`, `alu_in2`, `alu_op`) plus the sideband the execute stage needs.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `STALL_CNT_W`, 16: width of the saturating load-use stall counter.

Ports:
- `clk`  in  1  the single clock; everything is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid` / `in_ready`  in / out  1 / 1  decode handshake.
- `in_pc`  in  XLEN  instruction PC.
- `in_rs1`, `in_rs2`, `in_rd`  in  5 each  register indices.
- `in_rs1_data`, `in_rs2_data`  in  XLEN each  register-file read data.
- `in_imm`  in  XLEN  sign-extended immediate.
- `in_alu_op`  in  4  `ALU_OP_*` code.
- `in_src1_sel`  in  1  0 = rs1, 1 = pc.
- `in_src2_sel`  in  1  0 = rs2, 1 = imm.
- `in_rd_we`  in  1  instruction writes rd.
- `flush`  in  1  kill the held instruction (branch or trap redirect).
- `mem_rd`, `mem_rd_we`, `mem_is_load`, `mem_data`  in  5/1/1/XLEN  MEM-stage producer.
- `wb_rd`, `wb_rd_we`, `wb_data`  in  5/1/XLEN  WB-stage producer.
- `out_valid` / `out_ready`  out / in  1 / 1  execute handshake.
- `alu_in1`, `alu_in2`  out  XLEN each  ALU operands.
- `alu_op`  out  4  ALU operation code.
- `out_pc`, `out_rd`, `out_rd_we`  out  XLEN/5/1  sideband.
- `out_store_data`  out  XLEN  forwarded rs2 value, independent of `in_src2_sel`.
- `stall_cnt`  out  STALL_CNT_W  count of load-use bubble cycles, saturating.

## Operation
Register and handshake:
- Internal state: `valid_q` plus all `in_*` fields.
- `in_ready = !valid_q || (out_valid && out_ready)`.
- Capture happens when `in_valid && in_ready`.
- `valid_q` holds when the stage is stalled.

Forwarding:
- Applied combinationally from the held fields, once per source operand `rsN`.
- Priority order:
  - MEM, if `mem_rd_we && mem_rd==rsN && !mem_is_load`.
  - else WB, if `wb_rd_we && wb_rd==rsN`.
  - else the captured register-file data.
- Index 0 never forwards; its value is always 0.

Operand and output selection:
- `alu_in1 = src1_sel ? pc : fwd1`.
- `alu_in2 = src2_sel ? imm : fwd2`.
- `out_store_data = fwd2`.

Load-use hazard:
- `hazard = valid_q && mem_rd_we && mem_is_load && mem_rd!=0`, and `mem_rd` matches an operand that is actually used:
  - rs1 when `src1_sel==0`.
  - rs2 always, because store data also needs it.
- `out_valid = valid_q && !hazard`.
- While the hazard holds, the instruction stays in place and `in_ready=0`.
- The hazard clears once the load has advanced to WB, where it is then forwarded from WB.

Flush:
- On `flush`, `valid_q` goes to 0 on the next edge.
- A flush in the same cycle as an input capture drops the incoming instruction.
- Flush beats capture and beats hold.

Stall counter:
- Increments on every cycle with `hazard && out_ready`.
- Saturates at its maximum value; it never wraps.

## Timing
- Latency: 1 cycle from input capture to `out_valid`, when there is no hazard.
- Throughput: 1 instruction per cycle while `out_ready` stays high.
- Reset (asynchronous, while `rst_n` is low):
  - `valid_q=0`, therefore `out_valid=0` and `in_ready=1`.
  - All held fields are 0, so `alu_op=ALU_OP_ADD`, `alu_in1=alu_in2=0`, `out_rd_we=0`.
  - `stall_cnt=0`.
- Reset asserted mid-stall discards the held instruction. The first edge after release can capture.
- Backpressure with `out_ready=0`: all outputs hold and are stable, and `in_ready=0` while the stage is valid.
- Forwarding is combinational, so operand values can change during a hold as the producer stages advance. The consumer samples them only on a fire (`out_valid && out_ready`).
- With MEM and WB both matching the same register, MEM wins.

## Structure
- Shared `Defines` header holds:
  - the `ALU_OP_*` codes;
  - the `SRC1_RS1`/`SRC1_PC` and `SRC2_RS2`/`SRC2_IMM` select constants.
- Sub-module `fwd_mux`, instantiated twice (rs1 and rs2):
  - inputs: index, regfile data, and the MEM and WB producer ports;
  - outputs: the forwarded value and a `load_hit` flag.
- Top-level contents: the register, the handshake, the hazard logic and the counter.

## Test plan
- Back-to-back ADDI x1 then ADD x2,x1,x1 with `mem_rd=1`, `mem_data=5` → `alu_in1=alu_in2=5`. Then WB-only with `wb_data=7` → `alu_in1=alu_in2=7`.
- LW x3 in MEM (`mem_is_load=1`, `mem_rd=3`) while SUB x4,x3,x0 is held → `out_valid=0` and `in_ready=0` for exactly 1 cycle, `stall_cnt` goes 0→1. Next cycle WB forwards `wb_data=0x10` → `alu_in1=0x10`.
- Instruction with rs1=0 while MEM writes x0 with `0xDEAD` → `alu_in1=0`. AUIPC with pc `0x80` and imm `0x1000` → `alu_in1=0x80`, `alu_in2=0x1000`, and no hazard even though the load rd matches rs1.
- `out_ready` low for 3 cycles with a valid instruction → outputs stable and `in_ready=0`. `out_ready` high → fire, and a new capture in the same cycle.
- `flush` asserted together with `in_valid` → `out_valid=0` next cycle. `rst_n` pulsed low mid-stall → `out_valid=0`, `stall_cnt=0` immediately.
- Force 2^STALL_CNT_W+3 hazard cycles → `stall_cnt` saturates at all ones.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the decode-to-execute stage: ALU operation codes
// and operand-source select constants used by decode, this stage and the ALU.
package id_ex_stage_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned ALU_OP_W  = 4;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 4'h0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 4'h1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLL  = 4'h2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLT  = 4'h3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SLTU = 4'h4;
    localparam logic [ALU_OP_W-1:0] ALU_OP_XOR  = 4'h5;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRL  = 4'h6;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SRA  = 4'h7;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR   = 4'h8;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND  = 4'h9;
    localparam logic [ALU_OP_W-1:0] ALU_OP_PASS = 4'hA;

    localparam logic SRC1_RS1 = 1'b0;
    localparam logic SRC1_PC  = 1'b1;
    localparam logic SRC2_RS2 = 1'b0;
    localparam logic SRC2_IMM = 1'b1;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand bypass: picks MEM, then WB, then register-file data, and flags
// a MEM-stage load to this register (data not yet available).
module fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [REG_IDX_W-1:0] i_rs,
    input  logic [XLEN-1:0]      i_rf_data,
    input  logic [REG_IDX_W-1:0] i_mem_rd,
    input  logic                 i_mem_rd_we,
    input  logic                 i_mem_is_load,
    input  logic [XLEN-1:0]      i_mem_data,
    input  logic [REG_IDX_W-1:0] i_wb_rd,
    input  logic                 i_wb_rd_we,
    input  logic [XLEN-1:0]      i_wb_data,
    output logic [XLEN-1:0]      o_data,
    output logic                 o_load_hit
);

    logic w_rs_nonzero;
    logic w_mem_match;
    logic w_wb_match;

    assign w_rs_nonzero = (i_rs != '0);
    assign w_mem_match  = w_rs_nonzero && i_mem_rd_we && (i_mem_rd == i_rs);
    assign w_wb_match   = w_rs_nonzero && i_wb_rd_we  && (i_wb_rd  == i_rs);

    // A load in MEM has no data yet, so it falls through to WB/regfile here
    // and the top level holds the instruction until it reaches WB.
    assign o_load_hit = w_mem_match && i_mem_is_load;

    always_comb begin
        o_data = i_rf_data;
        if (!w_rs_nonzero) begin
            o_data = '0;
        end else if (w_mem_match && !i_mem_is_load) begin
            o_data = i_mem_data;
        end else if (w_wb_match) begin
            o_data = i_wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding and load-use
// stall insertion for the 5-stage RV32I core.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [REG_IDX_W-1:0]   in_rs1,
    input  logic [REG_IDX_W-1:0]   in_rs2,
    input  logic [REG_IDX_W-1:0]   in_rd,
    input  logic [XLEN-1:0]        in_rs1_data,
    input  logic [XLEN-1:0]        in_rs2_data,
    input  logic [XLEN-1:0]        in_imm,
    input  logic [ALU_OP_W-1:0]    in_alu_op,
    input  logic                   in_src1_sel,
    input  logic                   in_src2_sel,
    input  logic                   in_rd_we,
    input  logic                   flush,
    input  logic [REG_IDX_W-1:0]   mem_rd,
    input  logic                   mem_rd_we,
    input  logic                   mem_is_load,
    input  logic [XLEN-1:0]        mem_data,
    input  logic [REG_IDX_W-1:0]   wb_rd,
    input  logic                   wb_rd_we,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        alu_in1,
    output logic [XLEN-1:0]        alu_in2,
    output logic [ALU_OP_W-1:0]    alu_op,
    output logic [XLEN-1:0]        out_pc,
    output logic [REG_IDX_W-1:0]   out_rd,
    output logic                   out_rd_we,
    output logic [XLEN-1:0]        out_store_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Handshake: a transfer happens on a port in any cycle where its valid and
    // ready are both high; valid never depends on the same-side ready.
    logic                   r_valid;
    logic [XLEN-1:0]        r_pc;
    logic [REG_IDX_W-1:0]   r_rs1;
    logic [REG_IDX_W-1:0]   r_rs2;
    logic [REG_IDX_W-1:0]   r_rd;
    logic [XLEN-1:0]        r_rs1_data;
    logic [XLEN-1:0]        r_rs2_data;
    logic [XLEN-1:0]        r_imm;
    logic [ALU_OP_W-1:0]    r_alu_op;
    logic                   r_src1_sel;
    logic                   r_src2_sel;
    logic                   r_rd_we;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [XLEN-1:0]        w_fwd1;
    logic [XLEN-1:0]        w_fwd2;
    logic                   w_load_hit1;
    logic                   w_load_hit2;
    logic                   w_hazard;
    logic                   w_fire;
    logic                   w_capture;

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .i_rs          (r_rs1),
        .i_rf_data     (r_rs1_data),
        .i_mem_rd      (mem_rd),
        .i_mem_rd_we   (mem_rd_we),
        .i_mem_is_load (mem_is_load),
        .i_mem_data    (mem_data),
        .i_wb_rd       (wb_rd),
        .i_wb_rd_we    (wb_rd_we),
        .i_wb_data     (wb_data),
        .o_data        (w_fwd1),
        .o_load_hit    (w_load_hit1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .i_rs          (r_rs2),
        .i_rf_data     (r_rs2_data),
        .i_mem_rd      (mem_rd),
        .i_mem_rd_we   (mem_rd_we),
        .i_mem_is_load (mem_is_load),
        .i_mem_data    (mem_data),
        .i_wb_rd       (wb_rd),
        .i_wb_rd_we    (wb_rd_we),
        .i_wb_data     (wb_data),
        .o_data        (w_fwd2),
        .o_load_hit    (w_load_hit2)
    );

    // rs2 always counts as used because stores forward it as store data.
    assign w_hazard  = r_valid && ((w_load_hit1 && (r_src1_sel == SRC1_RS1)) || w_load_hit2);
    assign out_valid = r_valid && !w_hazard;
    assign w_fire    = out_valid && out_ready;
    assign in_ready  = !r_valid || w_fire;
    assign w_capture = in_valid && in_ready;

    assign alu_in1        = (r_src1_sel == SRC1_PC)  ? r_pc  : w_fwd1;
    assign alu_in2        = (r_src2_sel == SRC2_IMM) ? r_imm : w_fwd2;
    assign out_store_data = w_fwd2;
    assign alu_op         = r_alu_op;
    assign out_pc         = r_pc;
    assign out_rd         = r_rd;
    assign out_rd_we      = r_rd_we;
    assign stall_cnt      = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_alu_op   <= ALU_OP_ADD;
            r_src1_sel <= SRC1_RS1;
            r_src2_sel <= SRC2_RS2;
            r_rd_we    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid    <= 1'b1;
            r_pc       <= in_pc;
            r_rs1      <= in_rs1;
            r_rs2      <= in_rs2;
            r_rd       <= in_rd;
            r_rs1_data <= in_rs1_data;
            r_rs2_data <= in_rs2_data;
            r_imm      <= in_imm;
            r_alu_op   <= in_alu_op;
            r_src1_sel <= in_src1_sel;
            r_src2_sel <= in_src2_sel;
            r_rd_we    <= in_rd_we;
        end else if (w_fire) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
